// File: rtl/mips_lsu_pkg.sv
// Shared types and helpers for the MIPS load/store unit.
package mips_lsu_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } lsu_op_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    DONE   = 3'd5
  } lsu_state_t;

  // Word ops need a 4-byte aligned address, halfword ops a 2-byte aligned one.
  function automatic logic is_misaligned(lsu_op_t op, logic [1:0] offset);
    case (op)
      LW, SW:       return offset != 2'b00;
      LH, LHU, SH:  return offset[0];
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane steering: extracts/extends load lanes and merges store lanes
// into a word. Purely combinational; shared by the LOAD and RMW_WR paths.
module lsu_lane_align
  import mips_lsu_pkg::*;
(
  input  lsu_op_t            op,
  input  logic [1:0]         offset,
  input  logic [WORD_W-1:0]  rd_word,
  input  logic [15:0]        wdata,
  output logic [WORD_W-1:0]  load_data,
  output logic [WORD_W-1:0]  store_word
);

  logic        [7:0]  byte_lane;
  logic        [15:0] half_lane;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  // Select the addressed byte/halfword; offset 0 is the most significant lane.
  always_comb begin
    byte_lane = rd_word[31:24];
    case (offset)
      2'd0: byte_lane = rd_word[31:24];
      2'd1: byte_lane = rd_word[23:16];
      2'd2: byte_lane = rd_word[15:8];
      2'd3: byte_lane = rd_word[7:0];
      default: byte_lane = rd_word[31:24];
    endcase
    half_lane = offset[1] ? rd_word[15:0] : rd_word[31:16];
    byte_s    = $signed(byte_lane);
    half_s    = $signed(half_lane);
  end

  // Load extension: signed ops replicate the lane MSB, unsigned ops pad zeros.
  always_comb begin
    load_data = rd_word;
    case (op)
      LB:      load_data = WORD_W'(byte_s);
      LBU:     load_data = {24'd0, byte_lane};
      LH:      load_data = WORD_W'(half_s);
      LHU:     load_data = {16'd0, half_lane};
      default: load_data = rd_word;
    endcase
  end

  // Store merge: replace only the target lane of the word read back from memory.
  always_comb begin
    store_word = rd_word;
    if (op == SB) begin
      case (offset)
        2'd0: store_word[31:24] = wdata[7:0];
        2'd1: store_word[23:16] = wdata[7:0];
        2'd2: store_word[15:8]  = wdata[7:0];
        2'd3: store_word[7:0]   = wdata[7:0];
        default: store_word = rd_word;
      endcase
    end else if (op == SH) begin
      if (offset[1]) store_word[15:0]  = wdata;
      else           store_word[31:16] = wdata;
    end
  end

endmodule

// File: rtl/mips_load_store_unit.sv
// Load/store initiator between the CPU datapath and a word-wide data memory
// without byte enables; sub-word stores are done as read-modify-write.
module mips_load_store_unit
  import mips_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  lsu_op_t            req_op,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [WORD_W-1:0]  req_wdata,
  output logic               resp_valid,
  output logic [WORD_W-1:0]  resp_rdata,
  output logic               resp_error,
  output logic [ADDR_W-1:0]  data_address,
  output logic               data_read,
  output logic               data_write,
  output logic [WORD_W-1:0]  data_writedata,
  input  logic [WORD_W-1:0]  data_readdata
);

  lsu_state_t          state, state_next;
  lsu_op_t             op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [WORD_W-1:0]   merge_q;
  logic [WORD_W-1:0]   rdata_q;
  logic                err_q;
  logic                accept;
  logic                misaligned;
  logic [WORD_W-1:0]   lane_word;
  logic [WORD_W-1:0]   load_data;
  logic [WORD_W-1:0]   store_word;

  assign accept     = req_valid && (state == IDLE);
  assign misaligned = is_misaligned(req_op, req_addr[1:0]);

  // During RMW_WR the lane aligner merges into the captured word; otherwise it
  // looks at the live memory read data.
  assign lane_word = (state == RMW_WR) ? merge_q : data_readdata;

  lsu_lane_align u_lane_align (
    .op         (op_q),
    .offset     (addr_q[1:0]),
    .rd_word    (lane_word),
    .wdata      (wdata_q[15:0]),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // State register; reset aborts any operation, including a pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            state_next = DONE;
          end else begin
            case (req_op)
              SW:      state_next = STORE;
              SH, SB:  state_next = RMW_RD;
              default: state_next = LOAD;
            endcase
          end
        end
      end
      LOAD:    state_next = DONE;
      STORE:   state_next = DONE;
      RMW_RD:  state_next = RMW_WR;
      RMW_WR:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, merge capture and load result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= LW;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= misaligned;
      end
      if (state == LOAD)   rdata_q <= load_data;
      if (state == RMW_RD) merge_q <= data_readdata;
    end
  end

  // Memory-side strobes decode purely from state so reset drops them at once.
  always_comb begin
    data_read      = 1'b0;
    data_write     = 1'b0;
    data_address   = '0;
    data_writedata = '0;
    case (state)
      LOAD, RMW_RD: begin
        data_read    = 1'b1;
        data_address = {addr_q[ADDR_W-1:2], 2'b00};
      end
      STORE: begin
        data_write     = 1'b1;
        data_address   = {addr_q[ADDR_W-1:2], 2'b00};
        data_writedata = wdata_q;
      end
      RMW_WR: begin
        data_write     = 1'b1;
        data_address   = {addr_q[ADDR_W-1:2], 2'b00};
        data_writedata = store_word;
      end
      default: ;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign resp_error = (state == DONE) && err_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Scoreboard bench for mips_load_store_unit with a behavioural word memory.
module tb_mips_load_store_unit;
  import mips_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  lsu_op_t     req_op = LW;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  mips_load_store_unit #(.ADDR_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_error     (resp_error),
    .data_address   (data_address),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata)
  );

  always #5 clk = ~clk;

  // Word memory: combinational read, posedge write; bench preload port.
  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  assign data_readdata = mem[data_address[9:2]];
  always @(posedge clk) begin
    if (pl_en)           mem[pl_idx] <= pl_val;
    else if (data_write) mem[data_address[9:2]] <= data_writedata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
    int          reads;
    int          writes;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rdata = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every completion and checks memory traffic.
  int rd_cnt = 0;
  int wr_cnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (data_read || data_write)
        check("addr_align", {30'd0, data_address[1:0]}, 32'd0);
      if (data_read)  rd_cnt++;
      if (data_write) wr_cnt++;
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_error", {31'd0, resp_error}, {31'd0, e.err});
          check("latency_cycle", cyc, e.due);
          check("read_cycles", rd_cnt, e.reads);
          check("write_cycles", wr_cnt, e.writes);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  task automatic poke(logic [31:0] byte_addr, logic [31:0] val);
    pl_en  = 1'b1;
    pl_idx = byte_addr[9:2];
    pl_val = val;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  // Issue one request at a negedge and push its expected response.
  task automatic issue(lsu_op_t op, logic [31:0] addr, logic [31:0] wd,
                       logic [31:0] exp_rd, logic err, bit hold);
    int   n = 0;
    exp_t e;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd1, 32'd0);
      req_valid = 1'b0;
      return;
    end
    if (err) begin
      e.due = cyc + 1; e.reads = 0; e.writes = 0;
    end else if (op == SW) begin
      e.due = cyc + 2; e.reads = 0; e.writes = 1;
    end else if (op == SH || op == SB) begin
      e.due = cyc + 3; e.reads = 1; e.writes = 1;
    end else begin
      e.due = cyc + 2; e.reads = 1; e.writes = 0;
      last_rdata = exp_rd;
    end
    e.rdata = last_rdata;
    e.err   = err;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic check_idle(string tag);
    check({tag, "_req_ready"},  {31'd0, req_ready},  32'd1);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_error"}, {31'd0, resp_error}, 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_data_read"},  {31'd0, data_read},  32'd0);
    check({tag, "_data_write"}, {31'd0, data_write}, 32'd0);
    check({tag, "_data_addr"},  data_address, 32'd0);
    check({tag, "_data_wdata"}, data_writedata, 32'd0);
  endtask

  initial begin
    @(negedge clk);
    check_idle("reset");
    poke(32'h100, 32'h11223344);
    poke(32'h104, 32'h80FF0000);
    reset = 1'b0;
    @(negedge clk);

    // Loads with big-endian lane selection and extension
    issue(LB,  32'h102, 32'h0, 32'h00000033, 1'b0, 1'b0);
    issue(LB,  32'h104, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0);
    issue(LBU, 32'h104, 32'h0, 32'h00000080, 1'b0, 1'b0);
    issue(LH,  32'h104, 32'h0, 32'hFFFF80FF, 1'b0, 1'b0);
    issue(LHU, 32'h106, 32'h0, 32'h00000000, 1'b0, 1'b0);
    issue(LHU, 32'h104, 32'h0, 32'h000080FF, 1'b0, 1'b0);
    drain();

    // Sub-word stores by read-modify-write
    issue(SB, 32'h101, 32'h000000AA, 32'h0, 1'b0, 1'b0);
    drain();
    check("mem_after_sb", mem[8'h40], 32'h11AA3344);
    issue(SH, 32'h102, 32'h0000BEEF, 32'h0, 1'b0, 1'b0);
    drain();
    check("mem_after_sh", mem[8'h40], 32'h11AABEEF);

    // Full-word store and load back
    issue(SW, 32'h200, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    drain();
    check("mem_after_sw", mem[8'h80], 32'hDEADBEEF);
    issue(LW, 32'h200, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

    // Misaligned accesses complete with error and no memory traffic
    issue(LW, 32'h203, 32'h0, 32'h0, 1'b1, 1'b0);
    issue(LH, 32'h101, 32'h0, 32'h0, 1'b1, 1'b0);
    issue(SH, 32'h103, 32'h00001234, 32'h0, 1'b1, 1'b0);
    issue(SW, 32'h202, 32'h12345678, 32'h0, 1'b1, 1'b0);
    issue(LB, 32'h103, 32'h0, 32'hFFFFFFEF, 1'b0, 1'b0);
    drain();
    check("mem_after_err", mem[8'h40], 32'h11AABEEF);

    // Back-to-back with req_valid held high
    issue(LW,  32'h100, 32'h0, 32'h11AABEEF, 1'b0, 1'b1);
    issue(LHU, 32'h102, 32'h0, 32'h0000BEEF, 1'b0, 1'b1);
    issue(SB,  32'h203, 32'h00000012, 32'h0, 1'b0, 1'b1);
    issue(LW,  32'h200, 32'h0, 32'hDEADBE12, 1'b0, 1'b0);
    drain();

    // Reset during RMW_WR aborts the write and the response
    req_valid = 1'b1;
    req_op    = SB;
    req_addr  = 32'h100;
    req_wdata = 32'h00000055;
    check("rst_pre_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_busy_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rmw_read", {31'd0, data_read}, 32'd1);
    @(negedge clk);
    check("rst_rmw_write", {31'd0, data_write}, 32'd1);
    check("rst_rmw_wdata", data_writedata, 32'h55AABEEF);
    reset = 1'b1;
    #1;
    check_idle("abort");
    @(negedge clk);
    @(negedge clk);
    check("mem_after_abort", mem[8'h40], 32'h11AABEEF);
    reset = 1'b0;
    last_rdata = '0;
    @(negedge clk);

    issue(SH,  32'h103, 32'h0, 32'h0, 1'b1, 1'b0);
    issue(LBU, 32'h100, 32'h0, 32'h00000011, 1'b0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
